// File: rtl/mul_ctrl_pkg.sv
// Shared core definitions for the multiply controller: op codes, FSM states,
// multiplier signedness codes and result formatting.
`timescale 1ns/1ps
package mul_ctrl_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned OP_W  = 3;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned ST_W  = 2;
    localparam int unsigned SGN_W = 2;

    // Op encoding; 5-7 are reserved
    localparam logic [OP_W-1:0] OP_MUL    = 3'd0;
    localparam logic [OP_W-1:0] OP_MULH   = 3'd1;
    localparam logic [OP_W-1:0] OP_MULHSU = 3'd2;
    localparam logic [OP_W-1:0] OP_MULHU  = 3'd3;
    localparam logic [OP_W-1:0] OP_MULW   = 3'd4;

    // Controller states
    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
    localparam logic [ST_W-1:0] ST_WAIT  = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

    // Multiplier signedness: {rs1 signed, rs2 signed}
    localparam logic [SGN_W-1:0] SGN_SS = 2'b11;
    localparam logic [SGN_W-1:0] SGN_SU = 2'b10;
    localparam logic [SGN_W-1:0] SGN_UU = 2'b00;

    // True for op codes outside the defined set
    function automatic logic op_reserved(input logic [OP_W-1:0] op);
        return (op > OP_MULW);
    endfunction

    // Signedness code presented to the multiplier for each op
    function automatic logic [SGN_W-1:0] op_signed(input logic [OP_W-1:0] op);
        logic [SGN_W-1:0] sgn;
        case (op)
            OP_MUL, OP_MULH, OP_MULW: sgn = SGN_SS;
            OP_MULHSU:                sgn = SGN_SU;
            default:                  sgn = SGN_UU;
        endcase
        return sgn;
    endfunction

    // Select / extend the 128-bit product into the final rd value
    function automatic logic [XLEN-1:0] format_result(input logic [OP_W-1:0] op,
                                                      input logic [XLEN-1:0] hi,
                                                      input logic [XLEN-1:0] lo);
        logic [XLEN-1:0] res;
        case (op)
            OP_MUL:                        res = lo;
            OP_MULH, OP_MULHSU, OP_MULHU:  res = hi;
            OP_MULW:                       res = {{32{lo[31]}}, lo[31:0]};
            default:                       res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mul_ctrl.sv
// Multiply controller: accepts one op at a time, drives an external
// multiplier, formats the product and hands it to writeback.
`timescale 1ns/1ps
module mul_ctrl
    import mul_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [XLEN-1:0]   in_src1,
    input  logic [XLEN-1:0]   in_src2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              mul_valid,
    output logic              mul_flush,
    output logic              mulw,
    output logic [SGN_W-1:0]  mul_signed,
    output logic [XLEN-1:0]   multiplicand,
    output logic [XLEN-1:0]   multiplier,
    input  logic              mul_ready,
    input  logic              mul_out_valid,
    input  logic [XLEN-1:0]   result_hi,
    input  logic [XLEN-1:0]   result_lo
);

    logic [ST_W-1:0]  state_q;
    logic [ST_W-1:0]  state_d;
    logic             wait_armed_q;
    logic [OP_W-1:0]  op_q;
    logic [XLEN-1:0]  src1_q;
    logic [XLEN-1:0]  src2_q;
    logic             mulw_q;
    logic [SGN_W-1:0] sgn_q;
    logic             accept;
    logic             capture;

    assign multiplicand = src1_q;
    assign multiplier   = src2_q;
    assign mulw         = mulw_q;
    assign mul_signed   = sgn_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; flush and reset kill every handshake
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        mul_valid = 1'b0;
        out_valid = 1'b0;
        mul_flush = flush & ~rst;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = ~flush & ~rst;
                accept   = in_valid & in_ready;
                if (accept) begin
                    state_d = op_reserved(in_op) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mul_valid = ~flush & ~rst;
                if (mul_valid && mul_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                capture = wait_armed_q & mul_out_valid & ~flush & ~rst;
                if (capture) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = ~flush & ~rst;
                if (out_valid && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // Arms result capture after the first WAIT cycle so a stale sticky valid is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_armed_q <= 1'b0;
        end else begin
            wait_armed_q <= (state_q == ST_WAIT) & ~flush;
        end
    end

    // Operand, tag and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            mulw_q   <= 1'b0;
            sgn_q    <= '0;
            out_tag  <= '0;
            out_data <= '0;
        end else begin
            if (accept) begin
                op_q     <= in_op;
                src1_q   <= in_src1;
                src2_q   <= in_src2;
                mulw_q   <= (in_op == OP_MULW);
                sgn_q    <= op_signed(in_op);
                out_tag  <= in_tag;
                out_data <= '0;
            end
            if (capture) begin
                out_data <= format_result(op_q, result_hi, result_lo);
            end
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed self-checking bench for mul_ctrl with a behavioural multiplier.
`timescale 1ns/1ps
module tb_mul_ctrl;

    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [63:0]  in_src1;
    logic [63:0]  in_src2;
    logic [4:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic [4:0]   out_tag;
    logic         mul_valid;
    logic         mul_flush;
    logic         mulw;
    logic [1:0]   mul_signed;
    logic [63:0]  multiplicand;
    logic [63:0]  multiplier;
    logic         mul_ready;
    logic         mul_out_valid;
    logic [63:0]  result_hi;
    logic [63:0]  result_lo;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mul_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag),
        .mul_valid(mul_valid), .mul_flush(mul_flush), .mulw(mulw),
        .mul_signed(mul_signed), .multiplicand(multiplicand), .multiplier(multiplier),
        .mul_ready(mul_ready), .mul_out_valid(mul_out_valid),
        .result_hi(result_hi), .result_lo(result_lo)
    );

    // Behavioural multiplier: LAT-cycle latency, sticky valid until next accept
    logic         busy = 1'b0;
    logic         stall = 1'b0;
    logic         lazy_clear = 1'b0;
    logic         clear_pending = 1'b0;
    int           cnt = 0;
    logic [127:0] prod_q = '0;
    logic [127:0] a_ext, b_ext;

    assign mul_ready = ~busy & ~stall;

    always_comb begin
        if (mulw) begin
            a_ext = mul_signed[1] ? {{96{multiplicand[31]}}, multiplicand[31:0]} : {96'b0, multiplicand[31:0]};
            b_ext = mul_signed[0] ? {{96{multiplier[31]}}, multiplier[31:0]} : {96'b0, multiplier[31:0]};
        end else begin
            a_ext = mul_signed[1] ? {{64{multiplicand[63]}}, multiplicand} : {64'b0, multiplicand};
            b_ext = mul_signed[0] ? {{64{multiplier[63]}}, multiplier} : {64'b0, multiplier};
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            mul_out_valid <= 1'b0;
            clear_pending <= 1'b0;
            cnt <= 0;
            result_hi <= '0;
            result_lo <= '0;
        end else begin
            if (clear_pending) begin
                mul_out_valid <= 1'b0;
                clear_pending <= 1'b0;
            end
            if (mul_flush) begin
                busy <= 1'b0;
            end else if (mul_valid && mul_ready) begin
                busy   <= 1'b1;
                cnt    <= LAT;
                prod_q <= a_ext * b_ext;
                if (lazy_clear) clear_pending <= 1'b1;
                else mul_out_valid <= 1'b0;
            end else if (busy) begin
                if (cnt == 1) begin
                    busy          <= 1'b0;
                    mul_out_valid <= 1'b1;
                    result_hi     <= prod_q[127:64];
                    result_lo     <= prod_q[63:0];
                end
                cnt <= cnt - 1;
            end
        end
    end

    // Event counters
    int acc_cnt = 0;
    int xfer_cnt = 0;
    int nr_cnt = 0;
    int ov_cnt = 0;
    always @(posedge clk) begin
        if (mul_valid && mul_ready) acc_cnt <= acc_cnt + 1;
        if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 1;
        if (mul_valid && !mul_ready) nr_cnt <= nr_cnt + 1;
        if (out_valid) ov_cnt <= ov_cnt + 1;
    end

    // Directed op table
    localparam logic [2:0]  V_OP  [6] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd5};
    localparam logic [63:0] V_A   [6] = '{64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                          64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF, 64'd5};
    localparam logic [63:0] V_B   [6] = '{64'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd2, 64'd2, 64'd5};
    localparam logic [63:0] V_EXP [6] = '{64'h0000_0000_0000_000C, 64'd0, 64'd1,
                                          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0};
    localparam logic [1:0]  V_SGN [6] = '{2'b11, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00};
    localparam logic        V_W   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present an op and return one cycle after its accept edge
    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] tag);
        int n;
        in_op = op; in_src1 = a; in_src2 = b; in_tag = tag; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick;
            n++;
        end
        total++;
        if (in_ready !== 1'b1) $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        else passed++;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick;
            lat++;
        end
    endtask

    task automatic drain;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
        tick; tick;
        total++;
        if ({in_ready, out_valid, mul_valid, mul_flush} !== 4'b0000)
            $display("FAIL reset_ctrl: in_ready/out_valid/mul_valid/mul_flush=%b required 0000",
                     {in_ready, out_valid, mul_valid, mul_flush});
        else passed++;
        total++;
        if (out_data !== 64'd0 || out_tag !== 5'd0)
            $display("FAIL reset_out: data=%h tag=%h required 0/0", out_data, out_tag);
        else passed++;
        total++;
        if (multiplicand !== 64'd0 || multiplier !== 64'd0)
            $display("FAIL reset_operands: %h %h required 0 0", multiplicand, multiplier);
        else passed++;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        else passed++;
    endtask

    task automatic test_ops;
        int  lat;
        bit  hold_ok;
        for (int i = 0; i < 6; i++) begin
            send(V_OP[i], V_A[i], V_B[i], 5'(5 + i));
            if (i < 5) begin
                total++;
                if ({mul_valid, mulw, mul_signed} !== {1'b1, V_W[i], V_SGN[i]} ||
                    multiplicand !== V_A[i] || multiplier !== V_B[i])
                    $display("FAIL issue_map[%0d]: valid/mulw/sgn=%b a=%h b=%h required %b %h %h", i,
                             {mul_valid, mulw, mul_signed}, multiplicand, multiplier,
                             {1'b1, V_W[i], V_SGN[i]}, V_A[i], V_B[i]);
                else passed++;
            end
            lat = 0;
            hold_ok = 1'b1;
            while (!out_valid && lat < 40) begin
                if (multiplicand !== V_A[i] || multiplier !== V_B[i] ||
                    mul_signed !== V_SGN[i] || mulw !== V_W[i]) hold_ok = 1'b0;
                tick;
                lat++;
            end
            total++;
            if (!hold_ok) $display("FAIL operand_hold[%0d]: inputs changed, required stable", i);
            else passed++;
            total++;
            if (lat !== ((i < 5) ? 1 + LAT + 1 : 0))
                $display("FAIL latency[%0d]: %0d cycles required %0d", i, lat, (i < 5) ? LAT + 2 : 0);
            else passed++;
            total++;
            if (out_valid !== 1'b1 || out_data !== V_EXP[i] || out_tag !== 5'(5 + i))
                $display("FAIL result[%0d]: valid=%b data=%h tag=%0d required 1 %h %0d", i,
                         out_valid, out_data, out_tag, V_EXP[i], 5 + i);
            else passed++;
            drain;
        end
    endtask

    task automatic test_backpressure;
        int lat;
        int xb;
        bit ok;
        send(3'd0, 64'd6, 64'd7, 5'd9);
        wait_out(lat);
        xb = xfer_cnt;
        ok = 1'b1;
        repeat (5) begin
            if (!(out_valid === 1'b1 && out_data === 64'd42 && out_tag === 5'd9 && in_ready === 1'b0)) ok = 1'b0;
            tick;
        end
        total++;
        if (!ok) $display("FAIL bp_hold: valid=%b data=%h tag=%0d in_ready=%b required 1 2a 9 0",
                          out_valid, out_data, out_tag, in_ready);
        else passed++;
        drain;
        total++;
        if (xfer_cnt !== xb + 1 || out_valid !== 1'b0)
            $display("FAIL bp_release: transfers=%0d valid=%b required 1 0", xfer_cnt - xb, out_valid);
        else passed++;
    endtask

    task automatic test_flush_wait;
        int lat;
        int n;
        int nr_base;
        int ov_base;
        nr_base = nr_cnt;
        ov_base = ov_cnt;
        lazy_clear = 1'b1;
        send(3'd3, 64'd9, 64'd9, 5'd3);
        n = 0;
        while (!mul_out_valid && n < 20) begin
            tick;
            n++;
        end
        flush = 1'b1;
        #1;
        total++;
        if ({mul_flush, out_valid, in_ready, mul_valid} !== 4'b1000)
            $display("FAIL flush_wait_comb: mul_flush/out_valid/in_ready/mul_valid=%b required 1000",
                     {mul_flush, out_valid, in_ready, mul_valid});
        else passed++;
        tick;
        flush = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL flush_to_idle: in_ready=%b required 1", in_ready);
        else passed++;
        repeat (6) tick;
        total++;
        if (ov_cnt !== ov_base) $display("FAIL flushed_no_output: out_valid cycles=%0d required 0", ov_cnt - ov_base);
        else passed++;
        send(3'd0, 64'd5, 64'd7, 5'd12);
        wait_out(lat);
        total++;
        if (out_valid !== 1'b1 || out_data !== 64'd35 || out_tag !== 5'd12 || lat !== LAT + 2)
            $display("FAIL after_flush: valid=%b data=%h tag=%0d lat=%0d required 1 23 12 %0d",
                     out_valid, out_data, out_tag, lat, LAT + 2);
        else passed++;
        total++;
        if (nr_cnt !== nr_base) $display("FAIL valid_without_ready: cycles=%0d required 0", nr_cnt - nr_base);
        else passed++;
        drain;
        lazy_clear = 1'b0;
    endtask

    task automatic test_stall;
        int lat;
        int ab;
        bit ok;
        stall = 1'b1;
        ab = acc_cnt;
        send(3'd0, 64'd2, 64'd9, 5'd14);
        ok = 1'b1;
        repeat (3) begin
            if (mul_valid !== 1'b1) ok = 1'b0;
            tick;
        end
        total++;
        if (!ok || acc_cnt !== ab) $display("FAIL stall_hold: mul_valid held=%b accepts=%0d required 1 0", ok, acc_cnt - ab);
        else passed++;
        stall = 1'b0;
        wait_out(lat);
        total++;
        if (out_data !== 64'd18 || out_tag !== 5'd14 || acc_cnt !== ab + 1)
            $display("FAIL stall_result: data=%h tag=%0d accepts=%0d required 12 14 1", out_data, out_tag, acc_cnt - ab);
        else passed++;
        drain;
    endtask

    task automatic test_reset_mid;
        int ov_base;
        send(3'd0, 64'd3, 64'd3, 5'd1);
        tick; tick;
        rst = 1'b1;
        ov_base = ov_cnt;
        tick;
        rst = 1'b0;
        repeat (8) tick;
        total++;
        if (ov_cnt !== ov_base || in_ready !== 1'b1 || out_data !== 64'd0)
            $display("FAIL reset_mid: out_valid cycles=%0d in_ready=%b data=%h required 0 1 0",
                     ov_cnt - ov_base, in_ready, out_data);
        else passed++;
    endtask

    task automatic test_flush_done;
        send(3'd7, 64'd1, 64'd1, 5'd2);
        total++;
        if (out_valid !== 1'b1 || out_data !== 64'd0 || out_tag !== 5'd2)
            $display("FAIL reserved7: valid=%b data=%h tag=%0d required 1 0 2", out_valid, out_data, out_tag);
        else passed++;
        flush = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL flush_done_comb: out_valid=%b required 0", out_valid);
        else passed++;
        tick;
        flush = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL flush_done_idle: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        else passed++;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_src1 = '0; in_src2 = '0; in_tag = '0;
        test_reset;
        test_ops;
        test_backpressure;
        test_flush_wait;
        test_stall;
        test_reset_mid;
        test_flush_done;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  cancel any in-flight op
- in_valid  in  1  upstream op valid
- in_ready  out  1  block can accept an op
- in_op  in  3  0=MUL 1=MULH 2=MULHSU 3=MULHU 4=MULW; 5-7 reserved
- in_src1  in  64  rs1 value
- in_src2  in  64  rs2 value
- in_tag  in  5  destination tag
- out_valid  out  1  result valid to writeback
- out_ready  in  1  writeback accepts
- out_data  out  64  final rd value
- out_tag  out  5  tag of the op
- mul_valid  out  1  request to multiplier
- mul_flush  out  1  flush to multiplier
- mulw  out  1  32-bit multiply
- mul_signed  out  2  11 s*s, 10 s*u, 00 u*u
- multiplicand  out  64  rs1
- multiplier  out  64  rs2
- mul_ready  in  1  multiplier idle
- mul_out_valid  in  1  multiplier result valid; sticky high until its next accept
- result_hi  in  64  product bits 127:64
- result_lo  in  64  product bits 63:0
REQ-002 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-003 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-004 in_ready SHALL be 1 only in IDLE with flush=0.
REQ-005 IDLE: on in_valid&in_ready, register op, sources, and tag; go to ISSUE next cycle.
REQ-006 ISSUE: mul_valid=~flush; when mul_valid&mul_ready, go to WAIT next cycle; otherwise hold ISSUE.
REQ-007 mul_valid SHALL be 0 in every state except ISSUE, so it deasserts the cycle after acceptance.
REQ-008 WAIT: ignore mul_out_valid in the first WAIT cycle; on mul_out_valid=1 afterwards, capture the formatted result into out_data and go to DONE.
REQ-009 DONE: out_valid=1; out_data and out_tag stable until out_ready=1; on out_valid&out_ready, go to IDLE next cycle.
REQ-010 Operand mapping:
- multiplicand=src1, multiplier=src2.
- mulw=1 only for MULW.
- mul_signed: MUL 11, MULH 11, MULHSU 10, MULHU 00, MULW 11.
- All four multiplier inputs held constant from ISSUE entry until WAIT exit.
REQ-011 Result select:
- MUL: result_lo.
- MULH, MULHSU, MULHU: result_hi.
- MULW: sign-extend result_lo[31:0] to 64 bits.
REQ-012 A reserved op SHALL skip ISSUE/WAIT, go directly to DONE, and return out_data=0.
REQ-013 flush=1 in any state: mul_flush=1 combinationally, out_valid=0 the same cycle, state=IDLE next cycle, the op is discarded, and no out_valid is produced for it.
REQ-014 flush and in_valid in the same cycle: the op is not accepted.
REQ-015 After a flush, a new op in ISSUE SHALL wait for mul_ready=1 and SHALL NOT capture any stale mul_out_valid, per the REQ-008 first-cycle rule.
REQ-016 Minimum latency SHALL be: accept edge, then 1 ISSUE cycle, then (multiplier latency + 1) WAIT cycles, then DONE; one op in flight, no overlap.

Reset
REQ-017 On rst:
- state=IDLE.
- out_valid, mul_valid, mul_flush = 0.
- out_data = 0, out_tag = 0.
- Operand registers = 0.
REQ-018 Reset mid-operation SHALL abandon the op without producing out_valid; rst overrides flush and all handshakes.

Structure
REQ-019 The op encoding (3 bits) and the state enum SHALL live in the shared core package; the mul_signed codes belong there too.
REQ-020 Result formatting SHALL be a package function; no sub-module.

Verification
REQ-021 MUL src1=3, src2=4 -> out_data=0x0000_0000_0000_000C with matching tag.
REQ-022 MULH src1=src2=0xFFFF_FFFF_FFFF_FFFF -> out_data=0.
REQ-023 MULHU src1=0xFFFF_FFFF_FFFF_FFFF, src2=2 -> out_data=1; MULHSU same operands -> out_data=0xFFFF_FFFF_FFFF_FFFF.
REQ-024 MULW src1=0x7FFF_FFFF, src2=2 -> out_data=0xFFFF_FFFF_FFFF_FFFE.
REQ-025 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_data, and out_tag held; single transfer on release; in_ready=0 throughout.
REQ-026 Flush in WAIT, then MUL 5*7 issued -> no output for the flushed op; out_data=35 for the second op; mul_valid never asserted while mul_ready=0.
